// File: rtl/imem_loader_if.sv
// Byte-stream link into the program loader: valid/ready handshake carrying one byte per transfer.
// master = byte source (UART receiver / host), slave = loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a little-endian byte image into words, writes them to
// instruction memory and holds the core in reset until done. IMEM_LOADER_CHECKSUM_EN adds a checksum stage.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    imem_loader_if.slave     link,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t           state;
    state_t           state_nx;
    logic             ready_q;
    logic             ready_nx;
    logic             hold_nx;
    logic             done_nx;
    logic             error_nx;
    logic [1:0]       byte_idx;
    logic [23:0]      shreg;
    logic [CNT_W-1:0] n_words;
    logic             accept;
    logic             word_end;
    logic             last_word;
    logic             start_load;
    logic [31:0]      word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      acc;
`endif

    assign link.in_ready = ready_q;
    assign accept        = link.in_valid && ready_q;
    assign word_end      = accept && (byte_idx == 2'd3);
    assign word_c        = {link.in_data, shreg};
    assign last_word     = (words_loaded + CNT_W'(1)) == n_words;
    assign start_load    = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // State register; handshake and status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            ready_q   <= ready_nx;
            core_hold <= hold_nx;
            done      <= done_nx;
            error     <= error_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nx = S_LEN;
            end
            S_LEN: begin
                if (word_end) begin
                    if (word_c == 32'd0)                 state_nx = S_TAIL;
                    else if (word_c > 32'(MAX_WORDS))    state_nx = S_ERR;
                    else                                 state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (word_end && last_word) state_nx = S_TAIL;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_end) state_nx = (word_c == acc) ? S_DONE : S_ERR;
            end
`endif
            default: state_nx = state;
        endcase
    end

    always_comb begin
        ready_nx = 1'b0;
        hold_nx  = 1'b1;
        done_nx  = 1'b0;
        error_nx = 1'b0;
        case (state_nx)
            S_LEN, S_DATA, S_CSUM: ready_nx = 1'b1;
            S_DONE: begin
                done_nx = 1'b1;
                hold_nx = 1'b0;
            end
            S_ERR:   error_nx = 1'b1;
            default: ready_nx = 1'b0;
        endcase
    end

    // Byte assembly, word counting and the one-deep memory write register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx     <= '0;
            shreg        <= '0;
            n_words      <= '0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc          <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start_load) begin
                byte_idx     <= '0;
                shreg        <= '0;
                words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc          <= '0;
`endif
            end else if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= {link.in_data, shreg[23:8]};
                if (word_end && state == S_LEN) n_words <= CNT_W'(word_c);
                if (word_end && state == S_DATA) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
                    mem_wdata    <= word_c;
                    words_loaded <= words_loaded + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc          <= acc + word_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed images checked against a queue model.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;
    localparam int unsigned CW   = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [CW-1:0] words_loaded;

    imem_loader_if lnk();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .link         (lnk),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks     = 0;
    int          n_pass       = 0;
    int          stall_cycles = 0;
    logic [31:0] img[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Reference model: word i of the image lands at BASE + 4*i.
    function automatic logic [31:0] model_addr(input int i);
        return BASE + 32'(i) * 32'd4;
    endfunction

    function automatic int model_bad_writes();
        int bad = 0;
        foreach (obs_addr[i]) begin
            if (i >= img.size() || obs_addr[i] !== model_addr(i) || obs_data[i] !== img[i]) bad++;
        end
        return bad;
    endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'd0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction
`endif

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            lnk.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        lnk.in_valid = 1'b1;
        lnk.in_data  = b;
        while (lnk.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        stall_cycles += waited;
        if (waited >= 100) begin
            n_checks++;
            $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, want 1", lnk.in_ready, waited);
        end
        @(negedge clk);
        lnk.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8], gaps);
    endtask

    task automatic wait_end();
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            $display("FAIL end_timeout: done=%b error=%b, want one of them set", done, error);
        end
        #1;
    endtask

    // Full load of img: header, words (optional start pulse mid-DATA), checksum when enabled.
    task automatic load_image(input bit gaps, input bit inject);
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_word(32'(img.size()), gaps);
        foreach (img[i]) begin
            if (inject && i == 1) pulse_start();
            send_word(img[i], gaps);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(model_sum(), gaps);
`endif
        wait_end();
    endtask

    task automatic test_reset();
        lnk.in_valid = 1'b0;
        lnk.in_data  = 8'h00;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (lnk.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", lnk.in_ready); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== BASE) $display("FAIL rst_mem_addr: got %h want %h", mem_addr, BASE); else n_pass++;
        n_checks++; if (mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (core_hold !== 1'b1) $display("FAIL rst_core_hold: got %b want 1", core_hold); else n_pass++;
        n_checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_status: done=%b error=%b want 0/0", done, error); else n_pass++;
        n_checks++; if (words_loaded !== '0) $display("FAIL rst_words_loaded: got %0d want 0", words_loaded); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Bytes offered in IDLE must not be consumed.
        lnk.in_valid = 1'b1;
        lnk.in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++; if (lnk.in_ready !== 1'b0 || core_hold !== 1'b1) $display("FAIL idle_hold: in_ready=%b core_hold=%b want 0/1", lnk.in_ready, core_hold); else n_pass++;
        lnk.in_valid = 1'b0;
    endtask

    task automatic test_spec_image();
        img = '{32'h0000_0013, 32'h0010_0093};
        load_image(1'b0, 1'b0);
        n_checks++; if (obs_addr.size() != 2) $display("FAIL spec_write_count: got %0d want 2", obs_addr.size()); else n_pass++;
        n_checks++; if (obs_addr.size() < 2 || obs_addr[0] !== 32'h0 || obs_data[0] !== 32'h0000_0013) $display("FAIL spec_write0: wrong first write, want addr 0 data 00000013"); else n_pass++;
        n_checks++; if (obs_addr.size() < 2 || obs_addr[1] !== 32'h4 || obs_data[1] !== 32'h0010_0093) $display("FAIL spec_write1: wrong second write, want addr 4 data 00100093"); else n_pass++;
        n_checks++; if (words_loaded !== CW'(2)) $display("FAIL spec_words_loaded: got %0d want 2", words_loaded); else n_pass++;
        n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL spec_status: done=%b error=%b want 1/0", done, error); else n_pass++;
        n_checks++; if (core_hold !== 1'b0) $display("FAIL spec_core_hold: got %b want 0", core_hold); else n_pass++;
    endtask

    task automatic test_zero_length();
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        n_checks++; if (core_hold !== 1'b1 || done !== 1'b0 || lnk.in_ready !== 1'b1) $display("FAIL restart_from_done: core_hold=%b done=%b in_ready=%b want 1/0/1", core_hold, done, lnk.in_ready); else n_pass++;
        send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        wait_end();
        n_checks++; if (obs_addr.size() != 0) $display("FAIL zero_writes: got %0d want 0", obs_addr.size()); else n_pass++;
        n_checks++; if (done !== 1'b1 || core_hold !== 1'b0) $display("FAIL zero_done: done=%b core_hold=%b want 1/0", done, core_hold); else n_pass++;
        n_checks++; if (words_loaded !== '0) $display("FAIL zero_words_loaded: got %0d want 0", words_loaded); else n_pass++;
    endtask

    task automatic test_oversize();
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_word(32'(MAXW + 1), 1'b0);
        wait_end();
        n_checks++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL oversize_status: error=%b done=%b want 1/0", error, done); else n_pass++;
        n_checks++; if (core_hold !== 1'b1 || lnk.in_ready !== 1'b0) $display("FAIL oversize_hold: core_hold=%b in_ready=%b want 1/0", core_hold, lnk.in_ready); else n_pass++;
        n_checks++; if (obs_addr.size() != 0 || words_loaded !== '0) $display("FAIL oversize_writes: writes=%0d words_loaded=%0d want 0/0", obs_addr.size(), words_loaded); else n_pass++;
        pulse_start();
        n_checks++; if (lnk.in_ready !== 1'b1 || error !== 1'b0 || core_hold !== 1'b1) $display("FAIL restart_from_err: in_ready=%b error=%b core_hold=%b want 1/0/1", lnk.in_ready, error, core_hold); else n_pass++;
        // Close the reopened load with an empty image.
        send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        wait_end();
        n_checks++; if (done !== 1'b1) $display("FAIL oversize_recover: done=%b want 1", done); else n_pass++;
    endtask

    task automatic test_random_gaps();
        for (int r = 0; r < 4; r++) begin
            img.delete();
            repeat ((r == 0) ? 3 : $urandom_range(2, 6)) img.push_back($urandom());
            load_image(1'b1, 1'b1);
            n_checks++; if (obs_addr.size() != img.size()) $display("FAIL gaps_count[%0d]: got %0d want %0d", r, obs_addr.size(), img.size()); else n_pass++;
            n_checks++; if (model_bad_writes() != 0) $display("FAIL gaps_writes[%0d]: %0d wrong writes, want 0", r, model_bad_writes()); else n_pass++;
            n_checks++; if (done !== 1'b1 || words_loaded !== CW'(img.size())) $display("FAIL gaps_done[%0d]: done=%b words_loaded=%0d want 1/%0d", r, done, words_loaded, img.size()); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            img.delete();
            repeat ($urandom_range(1, 8)) img.push_back($urandom());
            stall_cycles = 0;
            load_image(1'b0, 1'b0);
            n_checks++; if (stall_cycles != 0) $display("FAIL b2b_stall[%0d]: got %0d stall cycles want 0", r, stall_cycles); else n_pass++;
            n_checks++; if (obs_addr.size() != img.size() || model_bad_writes() != 0) $display("FAIL b2b_writes[%0d]: %0d writes (%0d wrong) want %0d correct", r, obs_addr.size(), model_bad_writes(), img.size()); else n_pass++;
        end
    endtask

    task automatic test_max_words();
        img.delete();
        repeat (MAXW) img.push_back($urandom());
        load_image(1'b0, 1'b0);
        n_checks++; if (obs_addr.size() != MAXW || model_bad_writes() != 0) $display("FAIL max_writes: %0d writes (%0d wrong) want %0d correct", obs_addr.size(), model_bad_writes(), MAXW); else n_pass++;
        n_checks++; if (done !== 1'b1 || words_loaded !== CW'(MAXW)) $display("FAIL max_done: done=%b words_loaded=%0d want 1/%0d", done, words_loaded, MAXW); else n_pass++;
    endtask

    task automatic test_reset_mid();
        img.delete();
        repeat (4) img.push_back($urandom());
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_word(32'd4, 1'b0);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        send_byte(img[2][7:0], 1'b0);
        n_checks++; if (words_loaded !== CW'(2)) $display("FAIL mid_words_loaded: got %0d want 2", words_loaded); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0 || lnk.in_ready !== 1'b0) $display("FAIL mid_rst_handshake: mem_we=%b in_ready=%b want 0/0", mem_we, lnk.in_ready); else n_pass++;
        n_checks++; if (mem_addr !== BASE || mem_wdata !== 32'd0) $display("FAIL mid_rst_mem: addr=%h data=%h want %h/0", mem_addr, mem_wdata, BASE); else n_pass++;
        n_checks++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0) $display("FAIL mid_rst_status: hold=%b done=%b err=%b wl=%0d want 1/0/0/0", core_hold, done, error, words_loaded); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (obs_addr.size() != 2 || model_bad_writes() != 0) $display("FAIL mid_partial_writes: %0d writes (%0d wrong) want 2 correct", obs_addr.size(), model_bad_writes()); else n_pass++;
        load_image(1'b1, 1'b0);
        n_checks++; if (obs_addr.size() != 4 || model_bad_writes() != 0) $display("FAIL mid_reload: %0d writes (%0d wrong) want 4 correct", obs_addr.size(), model_bad_writes()); else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            img = '{32'h0000_0001, 32'hFFFF_FFFF};
            obs_addr.delete();
            obs_data.delete();
            pulse_start();
            send_word(32'd2, 1'b0);
            send_word(img[0], 1'b0);
            send_word(img[1], 1'b0);
            send_word((k == 0) ? 32'h0000_0000 : 32'h0000_0001, 1'b0);
            wait_end();
            if (k == 0) begin
                n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL csum_good: done=%b error=%b want 1/0", done, error); else n_pass++;
            end else begin
                n_checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) $display("FAIL csum_bad: error=%b done=%b core_hold=%b want 1/0/1", error, done, core_hold); else n_pass++;
            end
            n_checks++; if (obs_addr.size() != 2 || model_bad_writes() != 0) $display("FAIL csum_writes[%0d]: %0d writes (%0d wrong) want 2 correct", k, obs_addr.size(), model_bad_writes()); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_spec_image();
        test_zero_length();
        test_oversize();
        test_random_gaps();
        test_back_to_back();
        test_max_words();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the processor core.
- Receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them into the instruction/data memory through a single-cycle write port.
- Holds the core in reset until the image is fully loaded (and verified, when enabled).
- Sits between the host byte link (UART receiver / testbench) and the memory's write port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, largest accepted image in words; a larger header count is an error.
- CNT_W, 16, width of the internal word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- start, input, 1, one-cycle pulse that begins or restarts a load; honoured only in IDLE, DONE or ERR.
- in_valid, input, 1, byte-stream valid.
- in_data, input, 8, byte-stream data.
- in_ready, output, 1, loader accepts a byte; a byte is taken when in_valid && in_ready.
- mem_we, output, 1, single-cycle memory write strobe.
- mem_addr, output, 32, byte address of the write (word aligned).
- mem_wdata, output, 32, write data.
- core_hold, output, 1, keeps the processor in reset while 1.
- done, output, 1, level; image loaded successfully.
- error, output, 1, level; load aborted.
- words_loaded, output, CNT_W, count of words written in the current load.

Behaviour:
- Reset (rst=0, asynchronous) forces these values:
  - state IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0;
  - core_hold=1, done=0, error=0, words_loaded=0;
  - byte index and checksum accumulator cleared.
- Reset asserted mid-load abandons the load immediately; no partial write strobe is emitted after reset asserts.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: in_ready=0, core_hold=1. start -> LEN; clears words_loaded, byte index, accumulator, done, error.
- LEN: in_ready=1.
  - Four accepted bytes form N, little-endian (first byte = bits 7:0).
  - On the 4th byte: N=0 -> DONE (or CSUM if enabled); N>MAX_WORDS -> ERR; otherwise -> DATA.
- DATA: in_ready=1.
  - Bytes are assembled little-endian into a word.
  - The cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+4*words_loaded (pre-increment value), mem_wdata=the assembled word. words_loaded increments in that same cycle.
  - Back-to-back bytes are accepted with no stall; the write pipeline is one deep and never blocks in_ready.
  - After word N is accepted -> DONE (or CSUM).
  - mem_addr arithmetic is 32-bit and wraps modulo 2^32; no error on wrap.
- DONE: in_ready=0, done=1, core_hold=0 from the first cycle in DONE. start -> LEN, with core_hold=1 in the same cycle start is sampled.
- ERR: in_ready=0, error=1, core_hold=1. start -> LEN.
- Bytes arriving while in_ready=0 are not consumed; the upstream holds them.
- start arriving in LEN/DATA/CSUM is ignored.
- The final mem_we pulse of a load is always issued before or in the cycle done asserts; it is never dropped by the state change.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - An internal 32-bit accumulator sums every data word modulo 2^32.
  - After the last data word (or directly after LEN when N=0) the state is CSUM, with in_ready=1.
  - Four little-endian bytes are received and compared with the accumulator: equal -> DONE, unequal -> ERR.
  - Words already written stay in memory even on error.
- When undefined: no CSUM state and no accumulator; DATA (or LEN with N=0) goes straight to DONE.

Test Plan:
- Reset, then start; send 02 00 00 00, 13 00 00 00, 93 00 10 00 -> mem_we pulses at addr 0x0 data 0x00000013 and at addr 0x4 data 0x00100093; words_loaded=2; done=1; core_hold falls to 0.
- Start; send 00 00 00 00 -> no mem_we; done=1 (without checksum).
- Start; send header count 1025 (01 04 00 00) with MAX_WORDS=1024 -> error=1, core_hold=1, no writes; a following start re-enters LEN.
- Load of 3 words with in_valid toggled randomly and one start pulse injected mid-DATA -> the start is ignored; writes land at 0x0, 0x4, 0x8 with correct data.
- rst pulsed low after 2 of 4 words -> outputs take reset values asynchronously; no further mem_we; the next start reloads from BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: words 0x00000001 and 0xFFFFFFFF followed by checksum 00 00 00 00 -> done=1. The same image with checksum 01 00 00 00 -> error=1, core_hold=1.
